// File: rtl/bird_collision.sv
// Game-state controller sitting after the bird physics stage.
// Evaluates pipe/floor/ceiling collisions once per frame, counts pipes
// passed, and sequences IDLE -> ARMED -> PLAYING -> DEAD -> IDLE.
module bird_collision #(
  parameter int BIRD_W    = 16,
  parameter int BIRD_H    = 12,
  parameter int PIPE_W    = 40,
  parameter int GAP_H     = 120,
  parameter int SCREEN_H  = 480,
  parameter int GRACE     = 8,
  parameter int DEAD_HOLD = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [10:0] bird_x,
  input  logic [10:0] bird_y,
  input  logic [10:0] pipe_x,
  input  logic [10:0] gap_y,
  output logic        enable,
  output logic        game_over,
  output logic [7:0]  score
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PLAYING = 2'd2,
    DEAD    = 2'd3
  } state_t;

  // One counter serves both the grace window and the dead hold time.
  localparam int CNT_MAX = (GRACE > DEAD_HOLD) ? GRACE : DEAD_HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] GRACE_LAST = CNT_W'(GRACE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(DEAD_HOLD - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       score_reg, score_next;
  logic             scored_reg, scored_next;
  logic             enable_reg, game_over_reg;

  // Coordinates widened by one bit so that no sum below can wrap.
  logic [11:0] bx, by, px, gy;
  logic        hoverlap, pipe_hit, floor_hit, ceil_hit, hit;
  logic        passed, new_pipe;

  assign bx = {1'b0, bird_x};
  assign by = {1'b0, bird_y};
  assign px = {1'b0, pipe_x};
  assign gy = {1'b0, gap_y};

  assign hoverlap  = (bx + 12'(BIRD_W) > px) && (bx < px + 12'(PIPE_W));
  assign pipe_hit  = hoverlap && ((by < gy) || (by + 12'(BIRD_H) > gy + 12'(GAP_H)));
  assign floor_hit = (by + 12'(BIRD_H)) >= 12'(SCREEN_H);
  // A bird pushed above row 0 wraps to >= 1024, which reads as a ceiling hit.
  assign ceil_hit  = bird_y[10];
  assign hit       = pipe_hit || floor_hit || ceil_hit;

  // Pipe fully behind the bird, or a fresh pipe fully ahead of it.
  assign passed   = (px + 12'(PIPE_W)) < bx;
  assign new_pipe = px > (bx + 12'(BIRD_W));

  // Next-state, counter and score logic; everything holds by default.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    score_next  = score_reg;
    scored_next = scored_reg;
    case (state_reg)
      IDLE: begin
        // start wins over a coincident frame_tick.
        if (start) begin
          state_next  = ARMED;
          cnt_next    = '0;
          score_next  = '0;
          scored_next = 1'b0;
        end
      end
      ARMED: begin
        if (frame_tick) begin
          if (cnt_reg == GRACE_LAST) begin
            state_next = PLAYING;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      PLAYING: begin
        if (frame_tick) begin
          if (hit) begin
            // A fatal frame never scores.
            state_next = DEAD;
            cnt_next   = '0;
          end else begin
            if (!scored_reg && passed) begin
              scored_next = 1'b1;
              if (score_reg != 8'hFF) begin
                score_next = score_reg + 8'd1;
              end
            end
            if (new_pipe) begin
              scored_next = 1'b0;
            end
          end
        end
      end
      DEAD: begin
        if (frame_tick) begin
          if (cnt_reg == HOLD_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counters and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      score_reg     <= '0;
      scored_reg    <= 1'b0;
      enable_reg    <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      score_reg     <= score_next;
      scored_reg    <= scored_next;
      enable_reg    <= (state_next == ARMED) || (state_next == PLAYING);
      game_over_reg <= (state_next == DEAD);
    end
  end

  assign enable    = enable_reg;
  assign game_over = game_over_reg;
  assign score     = score_reg;

endmodule

// File: tb/tb_bird_collision.sv
// Scoreboard bench for bird_collision: a tick-level game model predicts
// enable/game_over/score for every cycle driven.
`timescale 1ns/1ps
module tb_bird_collision;

  localparam int P_BIRD_W   = 16;
  localparam int P_BIRD_H   = 12;
  localparam int P_PIPE_W   = 40;
  localparam int P_GAP_H    = 120;
  localparam int P_SCREEN_H = 480;
  localparam int P_GRACE    = 8;
  localparam int P_HOLD     = 60;

  localparam int S_IDLE = 0, S_ARMED = 1, S_PLAY = 2, S_DEAD = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        frame_tick = 1'b0;
  logic [10:0] bird_x = 11'd150;
  logic [10:0] bird_y = 11'd150;
  logic [10:0] pipe_x = 11'd600;
  logic [10:0] gap_y  = 11'd100;
  logic        enable;
  logic        game_over;
  logic [7:0]  score;

  typedef struct {
    logic       en;
    logic       go;
    logic [7:0] sc;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_state  = S_IDLE;
  int m_cnt    = 0;
  int m_score  = 0;
  bit m_scored = 0;

  bird_collision #(
    .BIRD_W(P_BIRD_W), .BIRD_H(P_BIRD_H), .PIPE_W(P_PIPE_W), .GAP_H(P_GAP_H),
    .SCREEN_H(P_SCREEN_H), .GRACE(P_GRACE), .DEAD_HOLD(P_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .bird_x(bird_x), .bird_y(bird_y), .pipe_x(pipe_x), .gap_y(gap_y),
    .enable(enable), .game_over(game_over), .score(score)
  );

  always #5 clk = ~clk;

  function automatic bit model_hit();
    int bx = int'(bird_x);
    int by = int'(bird_y);
    int px = int'(pipe_x);
    int gy = int'(gap_y);
    bit hov = (bx + P_BIRD_W > px) && (bx < px + P_PIPE_W);
    bit ph  = hov && ((by < gy) || (by + P_BIRD_H > gy + P_GAP_H));
    return ph || (by + P_BIRD_H >= P_SCREEN_H) || (by >= 1024);
  endfunction

  task automatic model_reset();
    m_state  = S_IDLE;
    m_cnt    = 0;
    m_score  = 0;
    m_scored = 0;
  endtask

  task automatic model_step(input logic t, input logic s);
    if (!reset) begin
      model_reset();
    end else if (s && m_state == S_IDLE) begin
      m_state = S_ARMED; m_cnt = 0; m_score = 0; m_scored = 0;
    end else if (t) begin
      case (m_state)
        S_ARMED: begin
          if (m_cnt == P_GRACE - 1) begin m_state = S_PLAY; m_cnt = 0; end
          else m_cnt++;
        end
        S_PLAY: begin
          if (model_hit()) begin
            m_state = S_DEAD; m_cnt = 0;
          end else begin
            if (!m_scored && (int'(pipe_x) + P_PIPE_W < int'(bird_x))) begin
              m_scored = 1;
              if (m_score < 255) m_score++;
            end
            if (int'(pipe_x) > int'(bird_x) + P_BIRD_W) m_scored = 0;
          end
        end
        S_DEAD: begin
          if (m_cnt == P_HOLD - 1) begin m_state = S_IDLE; m_cnt = 0; end
          else m_cnt++;
        end
        default: ;
      endcase
    end
  endtask

  // Drive one clock of stimulus, push the prediction, capture the DUT.
  task automatic cycle(input logic t, input logic s);
    obs_t e, o;
    frame_tick = t;
    start      = s;
    model_step(t, s);
    e.en = (m_state == S_ARMED) || (m_state == S_PLAY);
    e.go = (m_state == S_DEAD);
    e.sc = 8'(m_score);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    start      = 1'b0;
    o.en = enable;
    o.go = game_over;
    o.sc = score;
    obs_q.push_back(o);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    obs_t e, o;
    n_assert++;
    if ({enable, game_over, score} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got en=%0b go=%0b score=%0d, want 0 0 0", enable, game_over, score);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    reset = 1'b1;
    cycle(1'b0, 1'b1);
    n_assert++;
    if (enable !== 1'b1 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_then_start: got en=%0b go=%0b, want en=1 go=0", enable, game_over);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if ({o.en, o.go, o.sc} !== {e.en, e.go, e.sc}) begin
        n_fail++;
        $display("FAIL reset_sb: got en=%0b go=%0b sc=%0d, want en=%0b go=%0b sc=%0d", o.en, o.go, o.sc, e.en, e.go, e.sc);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_grace();
    obs_t e, o;
    bird_y = 11'd470;
    for (int i = 0; i < P_GRACE; i++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      n_assert++;
      if (game_over !== 1'b0 || enable !== 1'b1) begin
        n_fail++;
        $display("FAIL grace_tick%0d: got en=%0b go=%0b, want en=1 go=0", i + 1, enable, game_over);
      end
    end
    cycle(1'b1, 1'b0);
    n_assert++;
    if (game_over !== 1'b1 || enable !== 1'b0) begin
      n_fail++;
      $display("FAIL grace_floor_death: got en=%0b go=%0b, want en=0 go=1", enable, game_over);
    end
    bird_y = 11'd150;
    run_ticks(P_HOLD);
    n_assert++;
    if (game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL grace_back_idle: got go=%0b, want 0", game_over);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if ({o.en, o.go, o.sc} !== {e.en, e.go, e.sc}) begin
        n_fail++;
        $display("FAIL grace_sb: got en=%0b go=%0b sc=%0d, want en=%0b go=%0b sc=%0d", o.en, o.go, o.sc, e.en, e.go, e.sc);
      end
    end
    $display("test_grace done");
  endtask

  task automatic test_pipe_hit();
    obs_t e, o;
    bird_x = 11'd150; bird_y = 11'd150; pipe_x = 11'd600; gap_y = 11'd100;
    cycle(1'b0, 1'b1);
    run_ticks(P_GRACE);
    pipe_x = 11'd140;
    run_ticks(3);
    n_assert++;
    if (enable !== 1'b1 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL pipe_in_gap: got en=%0b go=%0b, want en=1 go=0", enable, game_over);
    end
    bird_y = 11'd50;
    cycle(1'b1, 1'b0);
    n_assert++;
    if (game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL pipe_hit_dead: got go=%0b, want 1", game_over);
    end
    bird_y = 11'd150; pipe_x = 11'd600;
    run_ticks(P_HOLD);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if ({o.en, o.go, o.sc} !== {e.en, e.go, e.sc}) begin
        n_fail++;
        $display("FAIL pipe_sb: got en=%0b go=%0b sc=%0d, want en=%0b go=%0b sc=%0d", o.en, o.go, o.sc, e.en, e.go, e.sc);
      end
    end
    $display("test_pipe_hit done");
  endtask

  task automatic test_scoring_and_ceiling();
    obs_t e, o;
    bird_x = 11'd150; bird_y = 11'd150; pipe_x = 11'd600; gap_y = 11'd100;
    cycle(1'b0, 1'b1);
    run_ticks(P_GRACE);
    for (int p = 300; p >= 0; p -= 4) begin
      pipe_x = 11'(p);
      cycle(1'b1, 1'b0);
      if (p == 112) begin
        n_assert++;
        if (score !== 8'd0) begin
          n_fail++;
          $display("FAIL score_before_pass: got %0d, want 0", score);
        end
      end
      if (p == 108) begin
        n_assert++;
        if (score !== 8'd1) begin
          n_fail++;
          $display("FAIL score_first_pass: got %0d, want 1", score);
        end
      end
    end
    n_assert++;
    if (score !== 8'd1) begin
      n_fail++;
      $display("FAIL score_held: got %0d, want 1", score);
    end
    for (int p = 600; p >= 0; p -= 4) begin
      pipe_x = 11'(p);
      cycle(1'b1, 1'b0);
    end
    n_assert++;
    if (score !== 8'd2) begin
      n_fail++;
      $display("FAIL score_second_pass: got %0d, want 2", score);
    end
    pipe_x = 11'd600;
    bird_y = 11'd2046;
    cycle(1'b1, 1'b0);
    n_assert++;
    if (game_over !== 1'b1 || score !== 8'd2) begin
      n_fail++;
      $display("FAIL ceiling_wrap: got go=%0b sc=%0d, want go=1 sc=2", game_over, score);
    end
    bird_y = 11'd150;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if ({o.en, o.go, o.sc} !== {e.en, e.go, e.sc}) begin
        n_fail++;
        $display("FAIL score_sb: got en=%0b go=%0b sc=%0d, want en=%0b go=%0b sc=%0d", o.en, o.go, o.sc, e.en, e.go, e.sc);
      end
    end
    $display("test_scoring_and_ceiling done");
  endtask

  task automatic test_dead_hold();
    obs_t e, o;
    run_ticks(10);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    n_assert++;
    if (game_over !== 1'b1 || enable !== 1'b0) begin
      n_fail++;
      $display("FAIL dead_start_ignored: got en=%0b go=%0b, want en=0 go=1", enable, game_over);
    end
    run_ticks(P_HOLD - 12);
    n_assert++;
    if (game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL dead_tick59: got go=%0b, want 1", game_over);
    end
    cycle(1'b1, 1'b0);
    n_assert++;
    if (game_over !== 1'b0 || enable !== 1'b0 || score !== 8'd2) begin
      n_fail++;
      $display("FAIL dead_to_idle: got en=%0b go=%0b sc=%0d, want 0 0 2", enable, game_over, score);
    end
    // start and tick together in IDLE: start wins
    cycle(1'b1, 1'b1);
    n_assert++;
    if (enable !== 1'b1 || score !== 8'd0) begin
      n_fail++;
      $display("FAIL restart_clear: got en=%0b sc=%0d, want en=1 sc=0", enable, score);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if ({o.en, o.go, o.sc} !== {e.en, e.go, e.sc}) begin
        n_fail++;
        $display("FAIL dead_sb: got en=%0b go=%0b sc=%0d, want en=%0b go=%0b sc=%0d", o.en, o.go, o.sc, e.en, e.go, e.sc);
      end
    end
    $display("test_dead_hold done");
  endtask

  task automatic test_saturation_and_reset();
    obs_t e, o;
    bird_x = 11'd150; bird_y = 11'd150; gap_y = 11'd100; pipe_x = 11'd600;
    // already ARMED from the restart; tick through the grace window
    run_ticks(P_GRACE);
    for (int i = 0; i < 255; i++) begin
      pipe_x = 11'd600; cycle(1'b1, 1'b0);
      pipe_x = 11'd50;  cycle(1'b1, 1'b0);
    end
    n_assert++;
    if (score !== 8'd255) begin
      n_fail++;
      $display("FAIL score_255: got %0d, want 255", score);
    end
    pipe_x = 11'd600; cycle(1'b1, 1'b0);
    pipe_x = 11'd50;  cycle(1'b1, 1'b0);
    n_assert++;
    if (score !== 8'd255 || enable !== 1'b1) begin
      n_fail++;
      $display("FAIL score_saturate: got sc=%0d en=%0b, want sc=255 en=1", score, enable);
    end
    // asynchronous reset between clock edges
    #2;
    reset = 1'b0;
    #1;
    n_assert++;
    if ({enable, game_over, score} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset: got en=%0b go=%0b sc=%0d, want 0 0 0", enable, game_over, score);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    run_ticks(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if ({o.en, o.go, o.sc} !== {e.en, e.go, e.sc}) begin
        n_fail++;
        $display("FAIL sat_sb: got en=%0b go=%0b sc=%0d, want en=%0b go=%0b sc=%0d", o.en, o.go, o.sc, e.en, e.go, e.sc);
      end
    end
    $display("test_saturation_and_reset done");
  endtask

  initial begin
    test_reset();
    test_grace();
    test_pipe_hit();
    test_scoring_and_ceiling();
    test_dead_hold();
    test_saturation_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
